// File: rtl/kelvin_irq_ctrl_if.sv
// Register-port bundle for kelvin_irq_ctrl: read/write strobes, address, write data,
// and the registered read-data return path.
interface kelvin_irq_ctrl_if;
    logic        cfg_we;
    logic        cfg_re;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        cfg_rvalid;

    modport master (output cfg_we, cfg_re, cfg_addr, cfg_wdata, input cfg_rdata, cfg_rvalid);
    modport slave  (input cfg_we, cfg_re, cfg_addr, cfg_wdata, output cfg_rdata, cfg_rvalid);
endinterface

// File: rtl/kelvin_irq_ctrl.sv
// Interrupt controller in front of the Kelvin core irq/te pins: pending/enable latching,
// fixed-priority claim/complete sequencing, fault/halt gating. KELVIN_IRQ_TIMEOUT_EN adds a timeout.
module kelvin_irq_ctrl #(
    parameter int NUM_SRC   = 8,
    parameter int TO_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src,
    kelvin_irq_ctrl_if.slave   cfg,
    output logic               irq,
    output logic               te,
    input  logic               halted,
    input  logic               fault,
    input  logic               wfi,
    output logic               busy,
    output logic               to_flag
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PEND    = 2'd1,
        S_SERVICE = 2'd2,
        S_FAULT   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic               te_q, te_d;
    logic               irq_q, irq_d;
    logic               busy_q, busy_d;
    logic               fault_seen_q, fault_seen_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;

    logic [NUM_SRC-1:0] eligible_s, w1c_mask_s, claim_mask_s;
    logic [4:0]         winner_id_s;
    logic               wr_s, rd_s, claim_s, complete_s, fault_clr_s, to_clr_s, to_flag_s;
    logic               unused_s;

    function automatic logic [4:0] lowest_id(input logic [NUM_SRC-1:0] vec);
        logic [4:0] id;
        id = 5'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            id = vec[i] ? 5'(i) : id;
        end
        return id;
    endfunction

    assign eligible_s  = pending_q & enable_q;
    assign winner_id_s = lowest_id(eligible_s);
    assign unused_s    = ^{cfg.cfg_wdata, wfi, to_clr_s, 32'(TO_CYCLES)};

    // Register-port decode; a write in the same cycle suppresses the read.
    always_comb begin
        wr_s         = cfg.cfg_we;
        rd_s         = cfg.cfg_re & ~cfg.cfg_we;
        claim_s      = rd_s && (cfg.cfg_addr == 2'd2) && (state_q == S_PEND) &&
                       (eligible_s != {NUM_SRC{1'b0}});
        complete_s   = wr_s && (cfg.cfg_addr == 2'd3) && cfg.cfg_wdata[1] && (state_q == S_SERVICE);
        fault_clr_s  = wr_s && (cfg.cfg_addr == 2'd3) && cfg.cfg_wdata[2];
        to_clr_s     = wr_s && (cfg.cfg_addr == 2'd3) && cfg.cfg_wdata[3];
        w1c_mask_s   = (wr_s && (cfg.cfg_addr == 2'd1)) ? cfg.cfg_wdata[NUM_SRC-1:0] : {NUM_SRC{1'b0}};
        claim_mask_s = {NUM_SRC{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_mask_s[i] = claim_s && (winner_id_s == 5'(i));
        end
    end

    // Delivery FSM; a core fault overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (fault) begin
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_IDLE:    state_d = ((eligible_s != {NUM_SRC{1'b0}}) && !halted) ? S_PEND : S_IDLE;
                S_PEND: begin
                    if (claim_s) begin
                        state_d = S_SERVICE;
                    end else if (eligible_s == {NUM_SRC{1'b0}}) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_PEND;
                    end
                end
                S_SERVICE: state_d = complete_s ? S_IDLE : S_SERVICE;
                S_FAULT:   state_d = fault_clr_s ? S_IDLE : S_FAULT;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Register file, pending latch and output next-values; new src events win over clears.
    always_comb begin
        pending_d = (pending_q & ~w1c_mask_s & ~claim_mask_s) | src;
        enable_d  = (wr_s && (cfg.cfg_addr == 2'd0)) ? cfg.cfg_wdata[NUM_SRC-1:0] : enable_q;
        te_d      = (wr_s && (cfg.cfg_addr == 2'd3)) ? cfg.cfg_wdata[0] : te_q;
        irq_d     = (state_d == S_PEND) && !halted;
        busy_d    = (state_d == S_SERVICE);
        if (fault) begin
            fault_seen_d = 1'b1;
        end else if ((state_q == S_FAULT) && (state_d == S_IDLE)) begin
            fault_seen_d = 1'b0;
        end else begin
            fault_seen_d = fault_seen_q;
        end
        rvalid_d = rd_s;
        rdata_d  = rdata_q;
        if (rd_s) begin
            case (cfg.cfg_addr)
                2'd0:    rdata_d = 32'(enable_q);
                2'd1:    rdata_d = 32'(pending_q);
                2'd2:    rdata_d = claim_s ? {27'd0, winner_id_s + 5'd1} : 32'd0;
                2'd3:    rdata_d = {28'd0, to_flag_s, fault_seen_q, 1'b0, te_q};
                default: rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State and register flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pending_q    <= {NUM_SRC{1'b0}};
            enable_q     <= {NUM_SRC{1'b0}};
            te_q         <= 1'b0;
            irq_q        <= 1'b0;
            busy_q       <= 1'b0;
            fault_seen_q <= 1'b0;
            rdata_q      <= 32'd0;
            rvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            te_q         <= te_d;
            irq_q        <= irq_d;
            busy_q       <= busy_d;
            fault_seen_q <= fault_seen_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

`ifdef KELVIN_IRQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_flag_q, to_flag_d;

    // Unclaimed-irq counter: saturates at TO_CYCLES, flag set once on arrival.
    always_comb begin
        if (state_q != S_PEND) begin
            to_cnt_d = {TO_W{1'b0}};
        end else if (irq_q && (to_cnt_q != TO_W'(TO_CYCLES))) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_d = to_cnt_q;
        end
        if ((to_cnt_d == TO_W'(TO_CYCLES)) && (to_cnt_q != TO_W'(TO_CYCLES))) begin
            to_flag_d = 1'b1;
        end else if (to_clr_s) begin
            to_flag_d = 1'b0;
        end else begin
            to_flag_d = to_flag_q;
        end
    end

    // Timeout flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q  <= {TO_W{1'b0}};
            to_flag_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            to_flag_q <= to_flag_d;
        end
    end

    assign to_flag_s = to_flag_q;
`else
    assign to_flag_s = 1'b0;
`endif

    assign irq            = irq_q;
    assign te             = te_q;
    assign busy           = busy_q;
    assign to_flag        = to_flag_s;
    assign cfg.cfg_rdata  = rdata_q;
    assign cfg.cfg_rvalid = rvalid_q;
endmodule

// File: tb/tb_kelvin_irq_ctrl.sv
// Self-checking bench for kelvin_irq_ctrl: register-access vector table plus directed
// sequences for claim/complete, priority, fault, halt, timeout and reset corners.
module tb_kelvin_irq_ctrl;
`ifdef KELVIN_IRQ_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] src;
    logic       halted, fault, wfi;
    logic       irq, te, busy, to_flag;
    logic [31:0] rd;
    int tests_run    = 0;
    int tests_failed = 0;

    kelvin_irq_ctrl_if cfg_if ();

    kelvin_irq_ctrl #(.NUM_SRC(8), .TO_CYCLES(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .src     (src),
        .cfg     (cfg_if.slave),
        .irq     (irq),
        .te      (te),
        .halted  (halted),
        .fault   (fault),
        .wfi     (wfi),
        .busy    (busy),
        .to_flag (to_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_te;
    } vec_t;
    vec_t vecs[14];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_if.cfg_we    = 1'b1;
        cfg_if.cfg_addr  = a;
        cfg_if.cfg_wdata = d;
        step();
        cfg_if.cfg_we    = 1'b0;
        cfg_if.cfg_wdata = 32'd0;
    endtask

    task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        cfg_if.cfg_re   = 1'b1;
        cfg_if.cfg_addr = a;
        step();
        cfg_if.cfg_re   = 1'b0;
        check1({name, "_rvalid"}, cfg_if.cfg_rvalid, 1'b1);
        check32(name, cfg_if.cfg_rdata, exp);
    endtask

    task automatic pulse(input logic [7:0] s);
        src = s;
        step();
        src = 8'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b0, 2'd0, 32'd0,          32'd0,    1'b0};
        vecs[1]  = '{1'b0, 2'd1, 32'd0,          32'd0,    1'b0};
        vecs[2]  = '{1'b0, 2'd2, 32'd0,          32'd0,    1'b0};
        vecs[3]  = '{1'b0, 2'd3, 32'd0,          32'd0,    1'b0};
        vecs[4]  = '{1'b1, 2'd0, 32'h0000_00A5,  32'd0,    1'b0};
        vecs[5]  = '{1'b0, 2'd0, 32'd0,          32'hA5,   1'b0};
        vecs[6]  = '{1'b1, 2'd0, 32'h0000_01FF,  32'd0,    1'b0};
        vecs[7]  = '{1'b0, 2'd0, 32'd0,          32'hFF,   1'b0};
        vecs[8]  = '{1'b1, 2'd3, 32'h0000_0001,  32'd0,    1'b1};
        vecs[9]  = '{1'b0, 2'd3, 32'd0,          32'h1,    1'b1};
        vecs[10] = '{1'b1, 2'd3, 32'hFFFF_FFF2,  32'd0,    1'b0};
        vecs[11] = '{1'b0, 2'd3, 32'd0,          32'h0,    1'b0};
        vecs[12] = '{1'b1, 2'd0, 32'h0000_0000,  32'd0,    1'b0};
        vecs[13] = '{1'b0, 2'd0, 32'd0,          32'h0,    1'b0};

        reset = 1'b1; src = 8'd0; halted = 1'b0; fault = 1'b0; wfi = 1'b0;
        cfg_if.cfg_we = 1'b0; cfg_if.cfg_re = 1'b0; cfg_if.cfg_addr = 2'd0; cfg_if.cfg_wdata = 32'd0;
        step(); step();
        reset = 1'b0;
        check1("rst_irq", irq, 1'b0);
        check1("rst_te", te, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_to_flag", to_flag, 1'b0);
        check1("rst_rvalid", cfg_if.cfg_rvalid, 1'b0);
        check32("rst_rdata", cfg_if.cfg_rdata, 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                cfg_write(vecs[i].addr, vecs[i].data);
            end else begin
                read_chk($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp_rd);
            end
            check1($sformatf("vec%0d_te", i), te, vecs[i].exp_te);
        end

        // Basic delivery with wfi asserted: irq two cycles after the src pulse.
        wfi = 1'b1;
        cfg_write(2'd0, 32'h05);
        pulse(8'h04);
        check1("b_irq_early", irq, 1'b0);
        step();
        check1("b_irq", irq, 1'b1);
        read_chk("b_claim", 2'd2, 32'd3);
        check1("b_irq_claimed", irq, 1'b0);
        check1("b_busy", busy, 1'b1);
        step();
        check1("b_rvalid_drop", cfg_if.cfg_rvalid, 1'b0);
        check32("b_rdata_hold", cfg_if.cfg_rdata, 32'd3);
        read_chk("b_pending", 2'd1, 32'd0);
        cfg_write(2'd3, 32'h2);
        check1("b_busy_done", busy, 1'b0);
        wfi = 1'b0;

        // Fixed priority with two simultaneous sources.
        cfg_write(2'd0, 32'hFF);
        pulse(8'h42);
        step();
        check1("c_irq", irq, 1'b1);
        read_chk("c_claim1", 2'd2, 32'd2);
        read_chk("c_pending", 2'd1, 32'h40);
        cfg_write(2'd3, 32'h2);
        step();
        check1("c_irq_again", irq, 1'b1);
        read_chk("c_claim2", 2'd2, 32'd7);
        cfg_write(2'd3, 32'h2);

        // Re-trigger during service, then simultaneous claim and src.
        pulse(8'h01);
        step();
        read_chk("d_claim", 2'd2, 32'd1);
        pulse(8'h01);
        read_chk("d_pending", 2'd1, 32'h01);
        cfg_write(2'd3, 32'h2);
        step();
        check1("d_irq", irq, 1'b1);
        src = 8'h01;
        read_chk("d_claim_sim", 2'd2, 32'd1);
        src = 8'd0;
        read_chk("d_pending_sim", 2'd1, 32'h01);
        cfg_write(2'd3, 32'h2);
        step();
        read_chk("d_claim_last", 2'd2, 32'd1);
        cfg_write(2'd3, 32'h2);

        // Set beats same-cycle W1C; ENABLE drop returns to IDLE.
        src = 8'h10;
        cfg_write(2'd1, 32'h10);
        src = 8'd0;
        read_chk("e_pending_set_wins", 2'd1, 32'h10);
        check1("e_irq", irq, 1'b1);
        cfg_write(2'd0, 32'h0);
        step();
        check1("e_irq_drop", irq, 1'b0);
        read_chk("e_claim_idle", 2'd2, 32'd0);
        read_chk("e_pending_kept", 2'd1, 32'h10);
        cfg_write(2'd1, 32'h10);
        read_chk("e_pending_w1c", 2'd1, 32'h0);
        cfg_write(2'd0, 32'hFF);

        // Fault gating and recovery.
        pulse(8'h01);
        step();
        check1("f_irq", irq, 1'b1);
        fault = 1'b1;
        step();
        check1("f_irq_fault", irq, 1'b0);
        read_chk("f_ctrl", 2'd3, 32'h4);
        fault = 1'b0;
        step();
        check1("f_irq_still", irq, 1'b0);
        cfg_write(2'd3, 32'h4);
        step();
        check1("f_irq_back", irq, 1'b1);
        read_chk("f_ctrl_clr", 2'd3, 32'h0);
        read_chk("f_claim", 2'd2, 32'd1);
        cfg_write(2'd3, 32'h2);

        // Halted holds irq low while staying pending.
        pulse(8'h04);
        step();
        check1("g_irq", irq, 1'b1);
        halted = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check1($sformatf("g_halted%0d", k), irq, 1'b0);
        end
        halted = 1'b0;
        step();
        check1("g_irq_resume", irq, 1'b1);
        read_chk("g_claim", 2'd2, 32'd3);
        cfg_write(2'd3, 32'h2);

        // Unclaimed timeout (flag only in the timeout build).
        pulse(8'h80);
        step();
        check1("t_irq", irq, 1'b1);
        repeat (15) step();
        check1("t_flag_early", to_flag, 1'b0);
        step();
        check1("t_flag", to_flag, TO_EN);
        read_chk("t_ctrl", 2'd3, {28'd0, TO_EN, 3'd0});
        cfg_write(2'd3, 32'h8);
        check1("t_flag_clr", to_flag, 1'b0);
        step();
        check1("t_flag_stays", to_flag, 1'b0);
        check1("t_irq_held", irq, 1'b1);
        read_chk("t_claim", 2'd2, 32'd8);
        cfg_write(2'd3, 32'h2);

        // Reset in the middle of service.
        cfg_write(2'd3, 32'h1);
        pulse(8'h01);
        step();
        read_chk("h_claim", 2'd2, 32'd1);
        check1("h_busy", busy, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check1("h_busy_rst", busy, 1'b0);
        check1("h_irq_rst", irq, 1'b0);
        check1("h_te_rst", te, 1'b0);
        check32("h_rdata_rst", cfg_if.cfg_rdata, 32'd0);
        read_chk("h_enable_rst", 2'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
